// File: rtl/uart_frame_parser.sv
// Frame decoder behind the 8N1 UART receiver: SYNC, LEN, PAYLOAD[LEN], CHK.
// Good payloads land in an in-place buffer readable through rd_addr/rd_data.
module uart_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              frame_valid,
  output logic [7:0]        frame_len,
  output logic              err_chk,
  output logic              err_len,
  output logic              err_timeout,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    GET_LEN,
    GET_PAYLOAD,
    GET_CHK
  } state_t;

  state_t           state;
  logic [7:0]       len;
  logic [7:0]       idx;
  logic [7:0]       chk_acc;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       payload [MAX_LEN];

  logic len_ok;
  assign len_ok = (rx_data != 8'd0) && (32'(rx_data) <= MAX_LEN);

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state       <= WAIT_SYNC;
      len         <= 8'd0;
      idx         <= 8'd0;
      chk_acc     <= 8'd0;
      cnt         <= '0;
      frame_valid <= 1'b0;
      frame_len   <= 8'd0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < int'(MAX_LEN); i++) payload[i] <= 8'd0;
    end else begin
      frame_valid <= 1'b0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      if (rx_valid) begin
        // A byte on the terminal-count cycle wins over the timeout.
        cnt <= '0;
        case (state)
          WAIT_SYNC: begin
            if (rx_data == SYNC_BYTE) begin
              state <= GET_LEN;
              busy  <= 1'b1;
            end
          end
          GET_LEN: begin
            if (len_ok) begin
              len     <= rx_data;
              chk_acc <= rx_data;
              idx     <= 8'd0;
              state   <= GET_PAYLOAD;
            end else begin
              err_len <= 1'b1;
              state   <= WAIT_SYNC;
              busy    <= 1'b0;
            end
          end
          GET_PAYLOAD: begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
              if (idx == 8'(i)) payload[i] <= rx_data;
            end
            chk_acc <= chk_acc ^ rx_data;
            idx     <= idx + 8'd1;
            if (idx == len - 8'd1) state <= GET_CHK;
          end
          GET_CHK: begin
            if (rx_data == chk_acc) begin
              frame_valid <= 1'b1;
              frame_len   <= len;
            end else begin
              err_chk <= 1'b1;
            end
            state <= WAIT_SYNC;
            busy  <= 1'b0;
          end
          default: begin
            state <= WAIT_SYNC;
            busy  <= 1'b0;
          end
        endcase
      end else if (state == WAIT_SYNC) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        err_timeout <= 1'b1;
        state       <= WAIT_SYNC;
        busy        <= 1'b0;
        cnt         <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Random-access read; addresses past the buffer read as zero.
  always_comb begin
    rd_data = 8'd0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = payload[i];
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser (ADDR_W=5, TIMEOUT_CYCLES=100).
module tb_uart_frame_parser;

  logic       clk_50MHz;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_valid;
  logic [7:0] frame_len;
  logic       err_chk;
  logic       err_len;
  logic       err_timeout;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int fv_seen  = 0;
  int chk_seen = 0;
  int len_seen = 0;
  int to_seen  = 0;

  uart_frame_parser #(
    .SYNC_BYTE     (8'hA5),
    .MAX_LEN       (16),
    .ADDR_W        (5),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_valid(frame_valid),
    .frame_len  (frame_len),
    .err_chk    (err_chk),
    .err_len    (err_len),
    .err_timeout(err_timeout),
    .busy       (busy)
  );

  initial clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  // Pulse tallies sampled mid-cycle, away from the active edge.
  always @(negedge clk_50MHz) begin
    if (!reset) begin
      fv_seen  += int'(frame_valid);
      chk_seen += int'(err_chk);
      len_seen += int'(err_len);
      to_seen  += int'(err_timeout);
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called at a negedge; strobes one byte on the next posedge.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk_50MHz);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_50MHz);
  endtask

  task automatic read(input string tag, input logic [4:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic tallies(input string tag, input int fv, input int ec, input int el, input int et);
    #1;
    check({tag, "_fv_cnt"}, 8'(fv_seen), 8'(fv));
    check({tag, "_chk_cnt"}, 8'(chk_seen), 8'(ec));
    check({tag, "_len_cnt"}, 8'(len_seen), 8'(el));
    check({tag, "_to_cnt"}, 8'(to_seen), 8'(et));
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rd_addr  = 5'd0;
    idle(3);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_len", frame_len, 8'd0);
    reset = 1'b0;
    idle(2);
    check("rst_fv", {7'd0, frame_valid}, 8'd0);
    read("rst_rd0", 5'd0, 8'h00);

    // Good frame, bytes back to back.
    send(8'hA5);
    check("good_busy_rise", {7'd0, busy}, 8'd1);
    send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    check("good_busy_mid", {7'd0, busy}, 8'd1);
    send(8'h03);
    check("good_fv", {7'd0, frame_valid}, 8'd1);
    check("good_len", frame_len, 8'd3);
    check("good_busy_fall", {7'd0, busy}, 8'd0);
    idle(1);
    check("good_fv_one_cycle", {7'd0, frame_valid}, 8'd0);
    read("good_rd0", 5'd0, 8'h11);
    read("good_rd1", 5'd1, 8'h22);
    read("good_rd2", 5'd2, 8'h33);
    read("good_rd15", 5'd15, 8'h00);
    read("good_rd16", 5'd16, 8'h00);
    read("good_rd31", 5'd31, 8'h00);
    tallies("good", 1, 0, 0, 0);

    // Bad checksum.
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h04);
    check("badchk_err", {7'd0, err_chk}, 8'd1);
    check("badchk_fv", {7'd0, frame_valid}, 8'd0);
    check("badchk_len", frame_len, 8'd3);
    check("badchk_busy", {7'd0, busy}, 8'd0);
    idle(1);
    check("badchk_one_cycle", {7'd0, err_chk}, 8'd0);
    tallies("badchk", 1, 1, 0, 0);

    // Length errors, then a minimal frame.
    send(8'hA5); send(8'h00);
    check("len0_err", {7'd0, err_len}, 8'd1);
    check("len0_busy", {7'd0, busy}, 8'd0);
    idle(1);
    send(8'hA5); send(8'h11);
    check("len17_err", {7'd0, err_len}, 8'd1);
    idle(1);
    send(8'hA5); send(8'h01); send(8'h5A); send(8'h5B);
    check("len1_fv", {7'd0, frame_valid}, 8'd1);
    check("len1_len", frame_len, 8'd1);
    idle(1);
    read("len1_rd0", 5'd0, 8'h5A);
    tallies("lenerr", 2, 1, 2, 0);

    // Leading garbage is dropped silently.
    send(8'h00); send(8'hFF); send(8'h3C);
    check("garbage_busy", {7'd0, busy}, 8'd0);
    send(8'hA5); send(8'h02); send(8'hAA); send(8'h55); send(8'hFD);
    check("garbage_fv", {7'd0, frame_valid}, 8'd1);
    check("garbage_len", frame_len, 8'd2);
    idle(1);
    read("garbage_rd0", 5'd0, 8'hAA);
    read("garbage_rd1", 5'd1, 8'h55);
    read("garbage_rd2_stale", 5'd2, 8'h33);
    tallies("garbage", 3, 1, 2, 0);

    // Timeout exactly 100 cycles after the last strobe.
    send(8'hA5); send(8'h02); send(8'h11);
    idle(99);
    check("to_not_yet", {7'd0, err_timeout}, 8'd0);
    check("to_busy_before", {7'd0, busy}, 8'd1);
    idle(1);
    check("to_pulse", {7'd0, err_timeout}, 8'd1);
    check("to_busy_after", {7'd0, busy}, 8'd0);
    idle(1);
    check("to_one_cycle", {7'd0, err_timeout}, 8'd0);
    tallies("timeout", 3, 1, 2, 1);

    // Byte on the terminal-count cycle suppresses the timeout.
    send(8'hA5); send(8'h02); send(8'h11);
    idle(99);
    send(8'h22);
    check("tc_no_to", {7'd0, err_timeout}, 8'd0);
    check("tc_busy", {7'd0, busy}, 8'd1);
    send(8'h31);
    check("tc_fv", {7'd0, frame_valid}, 8'd1);
    check("tc_len", frame_len, 8'd2);
    idle(1);
    read("tc_rd1", 5'd1, 8'h22);
    tallies("termcount", 4, 1, 2, 1);

    // Reset in mid-frame clears everything immediately.
    send(8'hA5); send(8'h02); send(8'h11);
    read("mid_rd0_written", 5'd0, 8'h11);
    reset = 1'b1;
    #1;
    check("midrst_busy", {7'd0, busy}, 8'd0);
    check("midrst_len", frame_len, 8'd0);
    check("midrst_rd0", rd_data, 8'h00);
    check("midrst_pulses", {4'd0, frame_valid, err_chk, err_len, err_timeout}, 8'd0);
    @(negedge clk_50MHz);
    reset = 1'b0;
    idle(1);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    check("postrst_fv", {7'd0, frame_valid}, 8'd1);
    check("postrst_len", frame_len, 8'd1);
    idle(1);
    read("postrst_rd0", 5'd0, 8'h7E);
    tallies("postrst", 5, 1, 2, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level frame decoder sitting directly downstream of the 8N1 UART receiver. It consumes the receiver's one-cycle `data_ready` strobe and its `data_out` byte, and extracts framed packets of the form SYNC, LEN, PAYLOAD[LEN], CHK. Validated payloads are held in an internal buffer that control logic reads through a random-access port. Malformed or stalled frames are discarded and reported with single-cycle error pulses.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `MAX_LEN`, default 16: maximum payload length in bytes.
- `ADDR_W`, default 4: width of the read address; requires 2^ADDR_W >= MAX_LEN.
- `TIMEOUT_CYCLES`, default 50000: inter-byte timeout in clock cycles (1 ms at 50 MHz).

Ports:
- `clk_50MHz`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `rx_valid`  in  1  one-cycle byte strobe; connects to the receiver's `data_ready`.
- `rx_data`  in  8  received byte; valid only while `rx_valid`=1.
- `rd_addr`  in  ADDR_W  payload buffer read index.
- `rd_data`  out  8  equals buf[rd_addr], combinational; 0 when rd_addr >= MAX_LEN.
- `frame_valid`  out  1  one-cycle pulse when a good frame completes.
- `frame_len`  out  8  length of the last good frame.
- `err_chk`  out  1  one-cycle pulse on checksum mismatch.
- `err_len`  out  1  one-cycle pulse on LEN = 0 or LEN > MAX_LEN.
- `err_timeout`  out  1  one-cycle pulse on inter-byte timeout.
- `busy`  out  1  high while state is not WAIT_SYNC.

## Operation
- **States and transitions.** All transitions occur only on `rx_valid`, except the timeout.
  - WAIT_SYNC: if byte == SYNC_BYTE, go to GET_LEN. Any other byte is dropped silently with no error.
  - GET_LEN:
    - LEN in 1..MAX_LEN: latch len, set chk_acc = LEN, set idx = 0, go to GET_PAYLOAD.
    - Otherwise: pulse `err_len` and go to WAIT_SYNC. The offending byte is not re-examined as a SYNC byte.
  - GET_PAYLOAD: write buf[idx] = byte, set chk_acc ^= byte, set idx += 1. When idx reaches len-1 on a write, go to GET_CHK.
  - GET_CHK:
    - byte == chk_acc: pulse `frame_valid`, set `frame_len` = len.
    - Otherwise: pulse `err_chk`.
    - In both cases go to WAIT_SYNC.
- **Checksum.** 8-bit XOR of LEN and all payload bytes. SYNC is excluded.
- **Buffer.** Single bank, written in place.
  - After `frame_valid`, contents remain stable until the payload byte of a following frame arrives. That is at least 3 byte times, which is the reader's window.
  - After any error, the buffer may hold partial new data; `frame_len` keeps its previous value.
- **Timeout.**
  - The counter clears on every `rx_valid` and while in WAIT_SYNC.
  - Otherwise it increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1: pulse `err_timeout`, go to WAIT_SYNC, clear the counter.
  - If `rx_valid` arrives on the terminal-count cycle, the byte wins: it is processed normally and no timeout occurs.
- **Exclusivity.** At most one of `frame_valid` / `err_*` pulses in any cycle.
- **Reset (asynchronous, any state, including mid-frame).**
  - State returns to WAIT_SYNC.
  - Counters, chk_acc, `frame_len`, and the buffer clear to 0.
  - All pulses are 0 and `busy` is 0.

## Timing
- All outputs except `rd_data` are registered.
- `frame_valid`, `err_chk`, `err_len` assert in the cycle after the `rx_valid` that carries the deciding byte, for exactly 1 cycle.
- `frame_len` updates in the same cycle that `frame_valid` asserts.
- `busy` rises in the cycle after the SYNC strobe and falls in the cycle the terminating pulse asserts.
- `err_timeout` asserts TIMEOUT_CYCLES cycles after the last accepted byte's strobe.
- A buffer write is visible on `rd_data` in the cycle after its strobe.
- Back-to-back `rx_valid` on consecutive cycles must be handled without loss, even though the UART never produces them.

## Test plan
- **Good frame.** Send A5 03 11 22 33 03. Expect:
  - one `frame_valid` pulse;
  - `frame_len` = 3;
  - `rd_addr` 0/1/2 → 11/22/33;
  - `rd_addr` = 15 → last stale or 0 value, and `rd_addr` >= 16 (ADDR_W=5 build) → 0;
  - no error pulses.
- **Bad checksum.** Send A5 03 11 22 33 04. Expect one `err_chk` pulse, no `frame_valid`, and `frame_len` unchanged from the prior value.
- **Length errors.** Send A5 00 and A5 11 (LEN = 17 > 16). Each gives one `err_len` pulse. A following A5 01 5A 5B is then accepted: `frame_valid` pulses, `frame_len` = 1, rd[0] = 5A.
- **Leading garbage.** Send 00 FF 3C A5 02 AA 55 FD. Expect no errors for the leading garbage, then `frame_valid` with `frame_len` = 2.
- **Timeout (TIMEOUT_CYCLES = 100).** Send A5 02 11, then idle. Expect:
  - `err_timeout` exactly 100 cycles after the 11 strobe;
  - `busy` drops;
  - a byte strobed on cycle 99 suppresses the timeout.
- **Reset mid-frame.** Assert `reset` after A5 02 11. Expect all outputs at 0 and `busy` = 0 immediately. A subsequent full frame A5 01 7E 7F decodes correctly.
